// File: rtl/sym_err_align.sv
// sym_err_align
//
// Symbol-error alignment and measurement block for the transmit/receive test
// chain. It sits after the symbol delay line and compares the delayed
// reference symbol with the receiver slicer decision.
//
// On a start pulse it steps the delay line through every tap. For each tap it
// discards a few settling strobes and then counts symbol errors over a fixed
// scan window. It locks the tap with the fewest errors, discards settling
// strobes again, and then counts symbol errors over a long measurement window.
// That count is the SER measurement.
//
// Ports:
//   sys_clk       in   1       system clock, the only clock
//   reset         in   1       synchronous, active-high
//   sym_clk_en    in   1       one-cycle symbol strobe; qualifies all counting
//   start         in   1       single-cycle pulse; starts scan + measurement
//   ref_sym       in   2       delayed reference symbol from the delay line
//   dec_sym       in   2       slicer decision symbol
//   delay_change  out  4       registered tap select to the delay line
//   err_count     out  CNT_W   measurement-window error count (saturating)
//   best_scan_err out  SCAN_W  scan error count of the chosen tap
//   busy          out  1       high in every state except IDLE and DONE
//   done          out  1       high in DONE
//
// Parameter limits: NUM_TAPS is 1..16, SETTLE >= 1, and SCAN_LEN must fit in
// SCAN_W bits.

module sym_err_align #(
    parameter int NUM_TAPS      = 11,
    parameter int SETTLE        = 2,
    parameter int SCAN_LEN      = 64,
    parameter int MEAS_LEN_LOG2 = 16,
    parameter int CNT_W         = 17,
    parameter int SCAN_W        = 7
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              sym_clk_en,
    input  logic              start,
    input  logic [1:0]        ref_sym,
    input  logic [1:0]        dec_sym,
    output logic [3:0]        delay_change,
    output logic [CNT_W-1:0]  err_count,
    output logic [SCAN_W-1:0] best_scan_err,
    output logic              busy,
    output logic              done
);

    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [3:0]          LAST_TAP    = 4'(NUM_TAPS - 1);
    localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_LEN - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SCAN,
        ST_LOCK_SETTLE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    state_t                   state;
    logic [3:0]               tap;
    logic [3:0]               best_tap;
    logic [SCAN_W-1:0]        best_err;
    logic [SCAN_W-1:0]        scan_err;
    logic [SCAN_W-1:0]        scan_cnt;
    logic [SETTLE_W-1:0]      settle_cnt;
    logic [MEAS_LEN_LOG2-1:0] meas_cnt;

    logic              sym_err;
    logic [SCAN_W-1:0] tap_err;
    logic              tap_better;
    logic [SCAN_W-1:0] next_best_err;
    logic [3:0]        next_best_tap;

    // Error on the current strobe, and the scan result for this tap if the
    // current strobe closes the scan window. The comparison is strict, so on
    // a tie the earlier (lower) tap is kept.
    always_comb begin
        sym_err       = (ref_sym != dec_sym);
        tap_err       = scan_err + SCAN_W'(sym_err);
        tap_better    = (tap_err < best_err);
        next_best_err = tap_better ? tap_err : best_err;
        next_best_tap = tap_better ? tap : best_tap;
    end

    // Control FSM with registered outputs. Only strobe cycles advance the
    // FSM or any counter. The one exception is start acceptance in IDLE/DONE,
    // which ignores the strobe: a strobe that coincides with start is not
    // counted toward settling.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            tap           <= '0;
            best_tap      <= '0;
            best_err      <= '1;
            scan_err      <= '0;
            scan_cnt      <= '0;
            settle_cnt    <= '0;
            meas_cnt      <= '0;
            delay_change  <= '0;
            err_count     <= '0;
            best_scan_err <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        tap          <= '0;
                        delay_change <= '0;
                        err_count    <= '0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        best_err     <= '1;
                        best_tap     <= '0;
                        settle_cnt   <= '0;
                        state        <= ST_SETTLE;
                    end
                end

                // Let the delay line output settle after a tap change.
                ST_SETTLE: begin
                    if (sym_clk_en) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            scan_cnt   <= '0;
                            scan_err   <= '0;
                            state      <= ST_SCAN;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end

                // Count errors for the current tap. The last strobe of the
                // window folds its own error into the tap result before that
                // result is compared with the best so far.
                ST_SCAN: begin
                    if (sym_clk_en) begin
                        if (scan_cnt == SCAN_LAST) begin
                            best_err <= next_best_err;
                            best_tap <= next_best_tap;
                            if (tap != LAST_TAP) begin
                                tap          <= tap + 4'd1;
                                delay_change <= tap + 4'd1;
                                state        <= ST_SETTLE;
                            end else begin
                                delay_change  <= next_best_tap;
                                best_scan_err <= next_best_err;
                                settle_cnt    <= '0;
                                state         <= ST_LOCK_SETTLE;
                            end
                        end else begin
                            scan_cnt <= scan_cnt + 1'b1;
                            scan_err <= tap_err;
                        end
                    end
                end

                // Let the delay line settle on the locked tap.
                ST_LOCK_SETTLE: begin
                    if (sym_clk_en) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            meas_cnt   <= '0;
                            state      <= ST_MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end

                // The error count updates live and saturates rather than
                // wrapping. The window is a power of two, so it closes when
                // the strobe counter is all ones.
                ST_MEASURE: begin
                    if (sym_clk_en) begin
                        if (sym_err && (err_count != '1)) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (meas_cnt == '1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            meas_cnt <= meas_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sym_err_align.sv
// tb_sym_err_align
//
// Randomized self-checking bench for sym_err_align. A behavioural delay line
// (a 32-deep symbol shift register indexed by delay_change) feeds ref_sym. The
// slicer decision is the same stream taken at a fixed tap, with optional
// noise, injected errors, or forced inversion.
//
// Every strobe that the DUT should count is recorded. At done, a reference
// model replays the strobe schedule with plain loops and derives the expected
// best tap, scan error, measurement count, total strobe count, and the tap
// select that should have been visible on each strobe.
//
// The DUT uses a short measurement window (2^10) and an 8-bit error counter so
// that each run stays small and counter saturation can be reached.

module tb_sym_err_align;

    localparam int NUM_TAPS      = 11;
    localparam int SETTLE        = 2;
    localparam int SCAN_LEN      = 64;
    localparam int MEAS_LEN_LOG2 = 10;
    localparam int CNT_W         = 8;
    localparam int SCAN_W        = 7;

    localparam int MEAS_LEN   = 1 << MEAS_LEN_LOG2;
    localparam int SCAN_TOTAL = NUM_TAPS * (SETTLE + SCAN_LEN);
    localparam int TOTAL      = SCAN_TOTAL + SETTLE + MEAS_LEN;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam int SLICER_TAP = 6;
    localparam int INJECT_GAP = 64;
    localparam int MAX_CYCLES = 12000;

    localparam int MODE_ALIGN = 0;
    localparam int MODE_TIE   = 1;
    localparam int MODE_SAT   = 2;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic              sym_clk_en;
    logic              start;
    logic [1:0]        ref_sym;
    logic [1:0]        dec_sym;
    logic [3:0]        delay_change;
    logic [CNT_W-1:0]  err_count;
    logic [SCAN_W-1:0] best_scan_err;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [1:0] line [0:31];
    logic [1:0] rec_ref [$];
    logic [1:0] rec_dec [$];
    int         rec_tap [$];
    int         busy_low;

    sym_err_align #(
        .NUM_TAPS     (NUM_TAPS),
        .SETTLE       (SETTLE),
        .SCAN_LEN     (SCAN_LEN),
        .MEAS_LEN_LOG2(MEAS_LEN_LOG2),
        .CNT_W        (CNT_W),
        .SCAN_W       (SCAN_W)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .sym_clk_en   (sym_clk_en),
        .start        (start),
        .ref_sym      (ref_sym),
        .dec_sym      (dec_sym),
        .delay_change (delay_change),
        .err_count    (err_count),
        .best_scan_err(best_scan_err),
        .busy         (busy),
        .done         (done)
    );

    always #5 sys_clk = ~sys_clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance the behavioural delay line by one symbol, then form ref/dec for
    // this strobe. The measurement-phase strobe index is used only to place
    // the injected errors.
    task automatic driveSymbol(input int mode, input int idx, input bit inject, input bit noise);
        int m;
        for (int i = 31; i > 0; i--) line[i] = line[i-1];
        line[0] = 2'($urandom);
        ref_sym = line[delay_change];
        dec_sym = line[SLICER_TAP];
        if (mode == MODE_TIE) begin
            ref_sym = 2'b01;
            dec_sym = 2'b01;
        end else if (mode == MODE_SAT) begin
            dec_sym = ~ref_sym;
        end else begin
            if (noise && ($urandom_range(0, 15) == 0))
                dec_sym = dec_sym ^ 2'($urandom_range(1, 3));
            m = idx - SCAN_TOTAL - SETTLE;
            if (inject && m >= 0 && (m % INJECT_GAP) == INJECT_GAP - 1)
                dec_sym[0] = ~dec_sym[0];
        end
    endtask

    // One full start-to-done run. Optionally pulse start while busy, or abort
    // with a 3-cycle reset once abort_at strobes have been counted.
    task automatic applyStimulus(input string name, input int mode, input bit inject,
                                 input bit noise, input int busy_start_at, input int abort_at);
        int  cycles;
        bit  finished;
        bit  pulsed;
        int  idx;
        int  e;
        int  best;
        int  best_tap;
        int  cnt;
        int  trace_bad;
        int  exp_tap;

        rec_ref.delete();
        rec_dec.delete();
        rec_tap.delete();
        busy_low = 0;
        pulsed   = 0;

        @(posedge sys_clk); #1;
        start      = 1'b1;
        sym_clk_en = 1'($urandom_range(0, 1));
        if (sym_clk_en) driveSymbol(mode, -1, 1'b0, 1'b0);
        else begin
            ref_sym = 2'($urandom);
            dec_sym = 2'($urandom);
        end
        @(posedge sys_clk); #1;
        start = 1'b0;
        checkOutput({name, ".busyAfterStart"}, int'(busy), 1);
        checkOutput({name, ".doneAfterStart"}, int'(done), 0);

        cycles   = 0;
        finished = 0;
        while (!finished && cycles < MAX_CYCLES) begin
            if (done) begin
                finished = 1;
            end else begin
                if (abort_at >= 0 && rec_ref.size() >= abort_at) begin
                    reset = 1'b1;
                    start = 1'b0;
                    repeat (3) begin
                        sym_clk_en = 1'($urandom_range(0, 1));
                        ref_sym    = 2'($urandom);
                        dec_sym    = ~ref_sym;
                        @(posedge sys_clk); #1;
                    end
                    checkOutput({name, ".rstDelayChange"}, int'(delay_change), 0);
                    checkOutput({name, ".rstErrCount"}, int'(err_count), 0);
                    checkOutput({name, ".rstBestScanErr"}, int'(best_scan_err), 0);
                    checkOutput({name, ".rstBusy"}, int'(busy), 0);
                    checkOutput({name, ".rstDone"}, int'(done), 0);
                    reset      = 1'b0;
                    sym_clk_en = 1'b0;
                    return;
                end
                if (!busy) busy_low++;
                start = 1'b0;
                if (!pulsed && busy_start_at >= 0 && rec_ref.size() >= busy_start_at) begin
                    start  = 1'b1;
                    pulsed = 1;
                end
                if ($urandom_range(0, 1) == 1) begin
                    sym_clk_en = 1'b1;
                    driveSymbol(mode, rec_ref.size(), inject, noise);
                    rec_ref.push_back(ref_sym);
                    rec_dec.push_back(dec_sym);
                    rec_tap.push_back(int'(delay_change));
                end else begin
                    sym_clk_en = 1'b0;
                    ref_sym    = 2'($urandom);
                    dec_sym    = 2'($urandom);
                end
                @(posedge sys_clk); #1;
                cycles++;
            end
        end
        start      = 1'b0;
        sym_clk_en = 1'b0;

        if (!finished) begin
            checkOutput({name, ".doneWithinBudget"}, 0, 1);
            return;
        end

        // Reference model: replay the strobe schedule over the recorded pairs.
        idx      = 0;
        best     = 1 << 30;
        best_tap = 0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            idx += SETTLE;
            e = 0;
            for (int j = 0; j < SCAN_LEN; j++) begin
                if (idx < rec_ref.size() && rec_ref[idx] != rec_dec[idx]) e++;
                idx++;
            end
            if (e < best) begin
                best     = e;
                best_tap = t;
            end
        end
        idx += SETTLE;
        cnt = 0;
        for (int j = 0; j < MEAS_LEN; j++) begin
            if (idx < rec_ref.size() && rec_ref[idx] != rec_dec[idx] && cnt < CNT_MAX) cnt++;
            idx++;
        end
        trace_bad = 0;
        for (int k = 0; k < rec_tap.size(); k++) begin
            exp_tap = (k < SCAN_TOTAL) ? k / (SETTLE + SCAN_LEN) : best_tap;
            if (rec_tap[k] != exp_tap) trace_bad++;
        end

        checkOutput({name, ".strobeCount"}, rec_ref.size(), TOTAL);
        checkOutput({name, ".delayChange"}, int'(delay_change), best_tap);
        checkOutput({name, ".bestScanErr"}, int'(best_scan_err), best);
        checkOutput({name, ".errCount"}, int'(err_count), cnt);
        checkOutput({name, ".busyAtDone"}, int'(busy), 0);
        checkOutput({name, ".tapTraceBad"}, trace_bad, 0);
        checkOutput({name, ".busyLowDuringRun"}, busy_low, 0);

        // Directed expectations that follow from the stimulus construction.
        if (mode == MODE_ALIGN && !noise) begin
            checkOutput({name, ".alignTap"}, int'(delay_change), SLICER_TAP);
            checkOutput({name, ".alignScanErr"}, int'(best_scan_err), 0);
            checkOutput({name, ".alignErrCount"}, int'(err_count), inject ? MEAS_LEN / INJECT_GAP : 0);
        end
        if (mode == MODE_TIE) begin
            checkOutput({name, ".tieTap"}, int'(delay_change), 0);
            checkOutput({name, ".tieScanErr"}, int'(best_scan_err), 0);
        end
        if (mode == MODE_SAT) begin
            checkOutput({name, ".satScanErr"}, int'(best_scan_err), SCAN_LEN);
            checkOutput({name, ".satErrCount"}, int'(err_count), CNT_MAX);
        end

        // done must hold in DONE while no start arrives.
        repeat (5) begin
            sym_clk_en = 1'($urandom_range(0, 1));
            ref_sym    = 2'($urandom);
            dec_sym    = ~ref_sym;
            @(posedge sys_clk); #1;
        end
        sym_clk_en = 1'b0;
        checkOutput({name, ".doneHolds"}, int'(done), 1);
        checkOutput({name, ".errCountHolds"}, int'(err_count), cnt);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) line[i] = 2'b00;
        reset      = 1'b1;
        start      = 1'b0;
        sym_clk_en = 1'b0;
        ref_sym    = 2'b00;
        dec_sym    = 2'b00;
        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("reset.delayChange", int'(delay_change), 0);
        checkOutput("reset.errCount", int'(err_count), 0);
        checkOutput("reset.bestScanErr", int'(best_scan_err), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.done", int'(done), 0);
        reset = 1'b0;

        $display("[TB] aligned run with injected measurement errors");
        applyStimulus("align", MODE_ALIGN, 1'b1, 1'b0, -1, -1);
        $display("[TB] noisy run");
        applyStimulus("noisy", MODE_ALIGN, 1'b0, 1'b1, -1, -1);
        $display("[TB] constant-symbol tie run");
        applyStimulus("tie", MODE_TIE, 1'b0, 1'b0, -1, -1);
        $display("[TB] inverted decisions, saturation run");
        applyStimulus("sat", MODE_SAT, 1'b0, 1'b0, -1, -1);
        $display("[TB] start pulsed while busy");
        applyStimulus("busyStart", MODE_ALIGN, 1'b0, 1'b0, 300, -1);
        $display("[TB] reset during measurement");
        applyStimulus("resetMid", MODE_SAT, 1'b0, 1'b0, -1, 1200);
        $display("[TB] run from idle after reset");
        applyStimulus("afterReset", MODE_ALIGN, 1'b1, 1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
